// File: rtl/control_unit_pkg.sv
// Shared widths, opcodes, IR field positions and state encoding for the
// multi-cycle control sequencer.
package control_unit_pkg;

    localparam int DATA_W    = 16;
    localparam int IR_W      = 9;
    localparam int REG_SEL_W = 3;
    localparam int NREG      = 1 << REG_SEL_W;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int X_MSB  = 5;
    localparam int X_LSB  = 3;
    localparam int Y_MSB  = 2;
    localparam int Y_LSB  = 0;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/control_unit_if.sv
// Bundles the sequencer's start/instruction inputs and its datapath control outputs.
interface control_unit_if;
    import control_unit_pkg::*;

    logic              run;
    logic [DATA_W-1:0] din;
    logic [NREG-1:0]   r_in;
    logic [NREG-1:0]   r_out;
    logic              a_in;
    logic              g_in;
    logic              g_out;
    logic              din_out;
    logic              add_sub;
    logic              done;
    logic [IR_W-1:0]   ir;

    modport master (
        output run, din,
        input  r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, ir
    );

    modport slave (
        input  run, din,
        output r_in, r_out, a_in, g_in, g_out, din_out, add_sub, done, ir
    );

endinterface

// File: rtl/control_unit_dec3to8.sv
// 3-bit select to 8-bit one-hot decoder; output is all-zero when disabled.
module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Sequences mv / mvi / add / sub over T0..T3 and drives the datapath
// load-enables and bus-source selects combinationally from (state, IR).
module control_unit
    import control_unit_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    control_unit_if.slave cu
);

    state_t          r_state;
    state_t          w_next;
    logic [IR_W-1:0] r_ir;

    logic [2:0] w_op;
    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [2:0] w_rout_sel;

    logic w_rin_en;
    logic w_rout_en;
    logic w_rout_use_x;
    logic w_a_in;
    logic w_g_in;
    logic w_g_out;
    logic w_din_out;
    logic w_add_sub;
    logic w_done;

    assign w_op = r_ir[OP_MSB:OP_LSB];
    assign w_x  = r_ir[X_MSB:X_LSB];
    assign w_y  = r_ir[Y_MSB:Y_LSB];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && cu.run) begin
                r_ir <= cu.din[IR_W-1:0];
            end
        end
    end

    always_comb begin
        w_next       = T0;
        w_rin_en     = 1'b0;
        w_rout_en    = 1'b0;
        w_rout_use_x = 1'b0;
        w_a_in       = 1'b0;
        w_g_in       = 1'b0;
        w_g_out      = 1'b0;
        w_din_out    = 1'b0;
        w_add_sub    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            T0: begin
                w_next = cu.run ? T1 : T0;
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout_en = 1'b1;
                        w_rin_en  = 1'b1;
                        w_done    = 1'b1;
                    end
                    OP_MVI: begin
                        w_din_out = 1'b1;
                        w_rin_en  = 1'b1;
                        w_done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout_en    = 1'b1;
                        w_rout_use_x = 1'b1;
                        w_a_in       = 1'b1;
                        w_next       = T2;
                    end
                    // reserved 1xx opcodes retire as a NOP
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            T2: begin
                w_rout_en = 1'b1;
                w_g_in    = 1'b1;
                w_add_sub = (w_op == OP_SUB);
                w_next    = T3;
            end
            T3: begin
                w_g_out  = 1'b1;
                w_rin_en = 1'b1;
                w_done   = 1'b1;
            end
            default: begin
                w_next = T0;
            end
        endcase
    end

    assign w_rout_sel = w_rout_use_x ? w_x : w_y;

    dec3to8 u_dec_in (
        .i_en     (w_rin_en),
        .i_sel    (w_x),
        .o_onehot (cu.r_in)
    );

    dec3to8 u_dec_out (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (cu.r_out)
    );

    assign cu.a_in    = w_a_in;
    assign cu.g_in    = w_g_in;
    assign cu.g_out   = w_g_out;
    assign cu.din_out = w_din_out;
    assign cu.add_sub = w_add_sub;
    assign cu.done    = w_done;
    assign cu.ir      = r_ir;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected outputs go into a
// scoreboard queue; a negedge monitor pops, compares and checks invariants.
module tb_control_unit;
    import control_unit_pkg::*;

    typedef struct packed {
        logic [7:0] r_in;
        logic [7:0] r_out;
        logic       a_in;
        logic       g_in;
        logic       g_out;
        logic       din_out;
        logic       add_sub;
        logic       done;
        logic [8:0] ir;
    } exp_t;

    logic clock;
    logic resetn;

    control_unit_if cu ();

    control_unit dut (
        .clock  (clock),
        .resetn (resetn),
        .cu     (cu.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    function automatic exp_t mk(input logic [7:0] ri, input logic [7:0] ro,
                                input logic a, input logic g, input logic go,
                                input logic dout, input logic asub, input logic dn,
                                input logic [8:0] irv);
        exp_t e;
        e.r_in = ri;  e.r_out = ro;  e.a_in = a;   e.g_in = g;
        e.g_out = go; e.din_out = dout; e.add_sub = asub; e.done = dn;
        e.ir = irv;
        return e;
    endfunction

    // One cycle: after the edge, drive inputs and queue what the current state must show.
    task automatic cyc(input string name, input logic run, input logic [15:0] d, input exp_t e);
        @(posedge clock);
        #1;
        cu.run = run;
        cu.din = d;
        q_exp.push_back(e);
        q_name.push_back(name);
    endtask

    function automatic exp_t zero(input logic [8:0] irv);
        return mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, irv);
    endfunction

    always @(negedge clock) begin
        exp_t  g;
        exp_t  e;
        string nm;
        int    nbus;
        g = mk(cu.r_in, cu.r_out, cu.a_in, cu.g_in, cu.g_out, cu.din_out,
               cu.add_sub, cu.done, cu.ir);
        if (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL %s: got r_in=%h r_out=%h a=%b g=%b gout=%b dout=%b as=%b done=%b ir=%h, want r_in=%h r_out=%h a=%b g=%b gout=%b dout=%b as=%b done=%b ir=%h",
                          nm, g.r_in, g.r_out, g.a_in, g.g_in, g.g_out, g.din_out, g.add_sub, g.done, g.ir,
                          e.r_in, e.r_out, e.a_in, e.g_in, e.g_out, e.din_out, e.add_sub, e.done, e.ir);
        end
        nbus = $countones(cu.r_out) + int'(cu.g_out) + int'(cu.din_out);
        n_checks++;
        if (nbus <= 1 && $countones(cu.r_in) <= 1 && !$isunknown(g)) n_pass++;
        else $display("FAIL invariant @%0t: bus drivers=%0d r_in=%h r_out=%h, want <=1 driver and one-hot/zero",
                      $time, nbus, cu.r_in, cu.r_out);
    end

    initial begin
        resetn = 1'b0;
        cu.run = 1'b0;
        cu.din = '0;

        cyc("reset_hold", 1, 16'h01FF, zero(9'h000));
        cyc("reset_hold2", 1, 16'h01FF, zero(9'h000));
        @(posedge clock); #1;
        resetn = 1'b1;
        cu.run = 1'b0;

        // mv R1,R5
        cyc("mv_t0",   1, 16'h000D, zero(9'h000));
        cyc("mv_t1",   0, 16'h0000, mk(8'h02, 8'h20, 0, 0, 0, 0, 0, 1, 9'h00D));
        cyc("mv_back", 0, 16'h0000, zero(9'h00D));

        // mvi R2,#3
        cyc("mvi_t0", 1, 16'h0050, zero(9'h00D));
        cyc("mvi_t1", 0, 16'h0003, mk(8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 9'h050));

        // run low in T0: IR must not follow din
        for (int i = 0; i < 5; i++)
            cyc("idle_t0", 0, 16'h01FF, zero(9'h050));

        // add R0,R7 with run toggled during execution, then back-to-back sub R0,R7
        cyc("add_t0", 1, 16'h0087, zero(9'h050));
        cyc("add_t1", 1, 16'h0087, mk(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 9'h087));
        cyc("add_t2", 0, 16'h0087, mk(8'h00, 8'h80, 0, 1, 0, 0, 0, 0, 9'h087));
        cyc("add_t3", 1, 16'h00C7, mk(8'h01, 8'h00, 0, 0, 1, 0, 0, 1, 9'h087));
        cyc("sub_t0", 1, 16'h00C7, zero(9'h087));
        cyc("sub_t1", 1, 16'h00C7, mk(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 9'h0C7));
        cyc("sub_t2", 1, 16'h00C7, mk(8'h00, 8'h80, 0, 1, 0, 0, 1, 0, 9'h0C7));
        cyc("sub_t3", 1, 16'h001B, mk(8'h01, 8'h00, 0, 0, 1, 0, 0, 1, 9'h0C7));

        // mv R3,R3 fetched back-to-back, then reserved opcode
        cyc("mvxx_t0", 1, 16'h001B, zero(9'h0C7));
        cyc("mvxx_t1", 1, 16'h0199, mk(8'h08, 8'h08, 0, 0, 0, 0, 0, 1, 9'h01B));
        cyc("rsv_t0",  1, 16'h0199, zero(9'h01B));
        cyc("rsv_t1",  0, 16'h0000, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 9'h199));
        cyc("rsv_back", 0, 16'h0000, zero(9'h199));

        // add R2,R2 interrupted by asynchronous reset in T2
        cyc("add22_t0", 1, 16'h0092, zero(9'h199));
        cyc("add22_t1", 0, 16'h0000, mk(8'h00, 8'h04, 1, 0, 0, 0, 0, 0, 9'h092));
        @(posedge clock); #2;
        resetn = 1'b0;
        q_exp.push_back(zero(9'h000));
        q_name.push_back("async_reset_t2");
        cyc("reset_mid", 0, 16'h0000, zero(9'h000));
        @(posedge clock); #1;
        resetn = 1'b1;
        q_exp.push_back(zero(9'h000));
        q_name.push_back("post_reset_t0");

        // mv R7,R0 after reset: clean start, no leftover done
        cyc("mv70_t0", 1, 16'h0038, zero(9'h000));
        cyc("mv70_t1", 0, 16'h0000, mk(8'h80, 8'h01, 0, 0, 0, 0, 0, 1, 9'h038));
        cyc("mv70_back", 0, 16'h0000, zero(9'h038));

        @(posedge clock);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
